// File: rtl/ex_branch_resolve.sv
// rtl/ex_branch_resolve.sv - EX-stage branch resolution, fetch redirect/flush, 2-bit BHT and branch counters
module ex_branch_resolve #(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid_ex,
  input  logic             i_stall_ex,
  input  logic             i_is_branch_ex,
  input  logic             i_is_jal_ex,
  input  logic             i_is_jalr_ex,
  input  logic [2:0]       i_funct3_ex,
  input  logic             i_br_less_ex,
  input  logic             i_br_equal_ex,
  output logic             o_br_un_ex,
  input  logic [31:0]      i_pc_ex,
  input  logic [31:0]      i_target_ex,
  input  logic             i_pred_taken_ex,
  input  logic [31:0]      i_if_pc,
  output logic             o_if_pred_taken,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush_if_id,
  output logic             o_flush_id_ex,
  output logic             o_illegal_br,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {S_IDLE, S_REDIRECT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        redirect_pc_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   br_count_q, mispred_count_q;
  logic [1:0]         bht_q [BHT_ENTRIES];

  logic               is_cond, illegal_f3, cond_taken, actual_taken;
  logic               resolve, mispredict, bht_upd;
  logic [31:0]        actual_pc;
  logic [IDX_W-1:0]   ex_idx, if_idx;
  logic [1:0]         bht_cur, bht_nxt;
  logic               unused_pc_bits;

  assign o_br_un_ex = i_funct3_ex[1];

  // JALR wins over JAL, which wins over a conditional branch, if decode ever flags several
  assign is_cond    = i_is_branch_ex & ~i_is_jal_ex & ~i_is_jalr_ex;
  assign illegal_f3 = (i_funct3_ex[2:1] == 2'b01);

  always_comb begin
    cond_taken = 1'b0;
    case (i_funct3_ex)
      3'b000:          cond_taken = i_br_equal_ex;
      3'b001:          cond_taken = ~i_br_equal_ex;
      3'b100, 3'b110:  cond_taken = i_br_less_ex;
      3'b101, 3'b111:  cond_taken = ~i_br_less_ex;
      default:         cond_taken = 1'b0;
    endcase
  end

  assign actual_taken = i_is_jal_ex | i_is_jalr_ex | (is_cond & cond_taken);
  assign actual_pc    = actual_taken ? {i_target_ex[31:1], 1'b0} : i_pc_ex + 32'd4;

  assign resolve    = i_valid_ex & ~i_stall_ex & (i_is_branch_ex | i_is_jal_ex | i_is_jalr_ex)
                    & (state_q == S_IDLE);
  assign mispredict = resolve & (i_is_jalr_ex | (actual_taken != i_pred_taken_ex));
  assign bht_upd    = resolve & is_cond & ~illegal_f3;

  assign ex_idx  = i_pc_ex[IDX_W+1:2];
  assign if_idx  = i_if_pc[IDX_W+1:2];
  assign bht_cur = bht_q[ex_idx];

  always_comb begin
    bht_nxt = bht_cur;
    if (actual_taken) begin
      if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
    end
  end

  assign o_if_pred_taken = bht_q[if_idx][1];
  assign unused_pc_bits  = ^{i_if_pc[31:IDX_W+2], i_if_pc[1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (mispredict) state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign o_redirect_valid = (state_q == S_REDIRECT);
  assign o_flush_if_id    = (state_q == S_REDIRECT);
  assign o_flush_id_ex    = (state_q == S_REDIRECT);
  assign o_redirect_pc    = redirect_pc_q;
  assign o_illegal_br     = illegal_q;
  assign o_br_count       = br_count_q;
  assign o_mispred_count  = mispred_count_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= S_IDLE;
      redirect_pc_q   <= 32'd0;
      illegal_q       <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q   <= state_d;
      illegal_q <= resolve & is_cond & illegal_f3;
      if (mispredict) redirect_pc_q <= actual_pc;
      if (resolve)    br_count_q <= br_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (mispredict) mispred_count_q <= mispred_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bht_upd)    bht_q[ex_idx] <= bht_nxt;
    end
  end

endmodule

// File: tb/tb_ex_branch_resolve.sv
// tb/tb_ex_branch_resolve.sv - self-checking bench for ex_branch_resolve against a behavioural model
module tb_ex_branch_resolve;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid_ex, i_stall_ex, i_is_branch_ex, i_is_jal_ex, i_is_jalr_ex;
  logic [2:0]  i_funct3_ex;
  logic        i_br_less_ex, i_br_equal_ex;
  logic        o_br_un_ex;
  logic [31:0] i_pc_ex, i_target_ex;
  logic        i_pred_taken_ex;
  logic [31:0] i_if_pc;
  logic        o_if_pred_taken, o_redirect_valid, o_flush_if_id, o_flush_id_ex, o_illegal_br;
  logic [31:0] o_redirect_pc, o_br_count, o_mispred_count;

  ex_branch_resolve #(.BHT_ENTRIES(16), .CNT_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid_ex(i_valid_ex), .i_stall_ex(i_stall_ex),
    .i_is_branch_ex(i_is_branch_ex), .i_is_jal_ex(i_is_jal_ex), .i_is_jalr_ex(i_is_jalr_ex),
    .i_funct3_ex(i_funct3_ex), .i_br_less_ex(i_br_less_ex), .i_br_equal_ex(i_br_equal_ex),
    .o_br_un_ex(o_br_un_ex), .i_pc_ex(i_pc_ex), .i_target_ex(i_target_ex),
    .i_pred_taken_ex(i_pred_taken_ex), .i_if_pc(i_if_pc), .o_if_pred_taken(o_if_pred_taken),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_flush_if_id(o_flush_if_id), .o_flush_id_ex(o_flush_id_ex), .o_illegal_br(o_illegal_br),
    .o_br_count(o_br_count), .o_mispred_count(o_mispred_count)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the spec says happened after each edge
  bit          m_redir = 0, m_ill = 0;
  logic [31:0] m_pc = 0, m_br = 0, m_mis = 0;
  int          m_bht [16];

  always @(posedge i_clk) begin
    bit taken, mis, res;
    logic [31:0] tgt;
    int idx;
    if (i_rst) begin
      m_redir = 0; m_ill = 0; m_pc = 0; m_br = 0; m_mis = 0;
      foreach (m_bht[k]) m_bht[k] = 1;
    end else begin
      res   = i_valid_ex && !i_stall_ex && (i_is_branch_ex || i_is_jal_ex || i_is_jalr_ex) && !m_redir;
      m_ill = 0;
      mis   = 0;
      if (res) begin
        if (i_is_jalr_ex) begin
          taken = 1; mis = 1;
        end else if (i_is_jal_ex) begin
          taken = 1; mis = !i_pred_taken_ex;
        end else begin
          case (i_funct3_ex)
            0: taken = i_br_equal_ex;
            1: taken = !i_br_equal_ex;
            4, 6: taken = i_br_less_ex;
            5, 7: taken = !i_br_less_ex;
            default: taken = 0;
          endcase
          mis = (taken != i_pred_taken_ex);
          if (i_funct3_ex == 2 || i_funct3_ex == 3) m_ill = 1;
          else begin
            idx = (i_pc_ex >> 2) % 16;
            if (taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else       m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
          end
        end
        tgt  = i_target_ex;
        tgt[0] = 1'b0;
        m_br = m_br + 1;
        if (mis) begin
          m_mis = m_mis + 1;
          m_pc  = taken ? tgt : i_pc_ex + 32'd4;
        end
      end
      m_redir = mis;
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("br_un", o_br_un_ex, i_funct3_ex[1]);
      chk("if_pred", o_if_pred_taken, (m_bht[(i_if_pc >> 2) % 16] >= 2));
      chk("redirect_valid", o_redirect_valid, m_redir);
      chk("flush_if_id", o_flush_if_id, m_redir);
      chk("flush_id_ex", o_flush_id_ex, m_redir);
      chk("redirect_pc", o_redirect_pc, m_pc);
      chk("illegal_br", o_illegal_br, m_ill);
      chk("br_count", o_br_count, m_br);
      chk("mispred_count", o_mispred_count, m_mis);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle_in();
    i_valid_ex = 0; i_stall_ex = 0; i_is_branch_ex = 0; i_is_jal_ex = 0; i_is_jalr_ex = 0;
    i_funct3_ex = 0; i_br_less_ex = 0; i_br_equal_ex = 0; i_pred_taken_ex = 0;
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                    input logic less, input logic eq, input logic pred);
    idle_in();
    i_valid_ex = 1; i_is_branch_ex = 1; i_funct3_ex = f3; i_pc_ex = pc; i_target_ex = tgt;
    i_br_less_ex = less; i_br_equal_ex = eq; i_pred_taken_ex = pred;
  endtask

  initial begin
    idle_in();
    i_rst = 1; i_pc_ex = 0; i_target_ex = 0; i_if_pc = 0;
    step();
    chk_en = 1;
    step();
    i_rst = 0;
    i_if_pc = 32'h40;
    #1;
    chk("rst_if_pred", o_if_pred_taken, 0);
    chk("rst_redirect", o_redirect_valid, 0);
    chk("rst_br_count", o_br_count, 0);
    chk("rst_mis_count", o_mispred_count, 0);

    br(3'b000, 32'h100, 32'h180, 0, 1, 0);
    step(); idle_in();
    chk("beq_redirect", o_redirect_valid, 1);
    chk("beq_redirect_pc", o_redirect_pc, 32'h180);
    chk("beq_flush", {o_flush_if_id, o_flush_id_ex}, 2'b11);
    chk("beq_br", o_br_count, 1);
    chk("beq_mis", o_mispred_count, 1);
    step();
    chk("beq_redirect_1cyc", o_redirect_valid, 0);
    i_if_pc = 32'h100; #1;
    chk("beq_bht10", o_if_pred_taken, 1);

    br(3'b110, 32'h104, 32'h900, 0, 0, 0);
    #1 chk("bltu_un", o_br_un_ex, 1);
    step();
    chk("bltu_noredir", o_redirect_valid, 0);
    chk("bltu_br", o_br_count, 2);
    step();
    br(3'b110, 32'h104, 32'h900, 1, 0, 1);
    step(); step(); idle_in();
    i_if_pc = 32'h104; #1;
    chk("bht_sat_low", o_if_pred_taken, 1);
    chk("bltu_mis", o_mispred_count, 1);

    br(3'b001, 32'h200, 32'h280, 0, 0, 0);
    step();
    chk("bne_redirect_pc", o_redirect_pc, 32'h280);
    br(3'b000, 32'h300, 32'h380, 0, 1, 0);
    step(); idle_in();
    chk("wrongpath_redirect", o_redirect_valid, 0);
    chk("wrongpath_br", o_br_count, 6);
    chk("wrongpath_mis", o_mispred_count, 2);

    i_valid_ex = 1; i_is_jalr_ex = 1; i_pc_ex = 32'h400; i_target_ex = 32'h203; i_pred_taken_ex = 1;
    step(); idle_in();
    chk("jalr_redirect", o_redirect_valid, 1);
    chk("jalr_pc", o_redirect_pc, 32'h202);
    chk("jalr_mis", o_mispred_count, 3);
    step();

    br(3'b010, 32'h108, 32'h700, 0, 0, 0);
    step(); idle_in();
    chk("illegal_pulse", o_illegal_br, 1);
    chk("illegal_noredir", o_redirect_valid, 0);
    chk("illegal_br", o_br_count, 8);
    step();
    chk("illegal_1cyc", o_illegal_br, 0);

    br(3'b000, 32'h10C, 32'h500, 0, 1, 0);
    i_stall_ex = 1;
    step();
    chk("stall_noredir", o_redirect_valid, 0);
    step();
    chk("stall_br", o_br_count, 8);
    i_stall_ex = 0;
    step(); idle_in();
    chk("unstall_redirect", o_redirect_valid, 1);
    chk("unstall_pc", o_redirect_pc, 32'h500);
    step();

    br(3'b000, 32'h100, 32'h180, 0, 1, 0);
    step(); idle_in();
    chk("pre_rst_redirect", o_redirect_valid, 1);
    i_rst = 1;
    step();
    i_rst = 0;
    i_if_pc = 32'h100; #1;
    chk("rst_abort_redirect", o_redirect_valid, 0);
    chk("rst_abort_pc", o_redirect_pc, 0);
    chk("rst_abort_bht", o_if_pred_taken, 0);

    for (int n = 0; n < 3000; n++) begin
      int kind;
      idle_in();
      kind = $urandom_range(0, 9);
      i_valid_ex      = ($urandom % 8) != 0;
      i_stall_ex      = ($urandom % 5) == 0;
      i_is_branch_ex  = kind <= 4;
      i_is_jal_ex     = kind == 5;
      i_is_jalr_ex    = kind == 6;
      i_funct3_ex     = 3'($urandom);
      i_br_less_ex    = 1'($urandom);
      i_br_equal_ex   = 1'($urandom);
      i_pred_taken_ex = 1'($urandom);
      i_pc_ex         = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : {24'h0, 6'($urandom), 2'b00};
      i_target_ex     = $urandom;
      i_if_pc         = {24'h0, 6'($urandom), 2'($urandom)};
      i_rst           = ($urandom % 200) == 0;
      step();
    end
    i_rst = 0;
    idle_in();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
